acc_reg_file: RTL

ACC_REG_FILE -- requirements
Module: acc_reg_file

---
 rtl/acc_rf_pkg.sv | 14 +
 rtl/acc_rf_ctx_seq.sv | 83 ++++++++
 rtl/acc_reg_file.sv | 105 ++++++++++
 3 files changed

// File: rtl/acc_rf_pkg.sv
// Shared types and default sizing for the accumulator register file.
package acc_rf_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_PW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } ctx_state_t;

endpackage

// File: rtl/acc_rf_ctx_seq.sv
// Context save/restore sequencer: walks every register index once, one per
// memory acknowledge, and drives the memory handshake.
module acc_rf_ctx_seq
    import acc_rf_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_ctx_save,
    input  logic          i_ctx_restore,
    input  logic          i_mem_ack,
    output logic          o_busy,
    output logic          o_ctx_done,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [PW-1:0] o_mem_addr,
    output logic          o_restore_we
);

    localparam logic [PW-1:0] LAST_IDX = '1;

    ctx_state_t    r_state;
    ctx_state_t    w_state_next;
    logic [PW-1:0] r_index;
    logic [PW-1:0] w_index_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_ctx_done   = 1'b0;
        o_restore_we = 1'b0;
        case (r_state)
            IDLE: begin
                // Save wins when both requests arrive together.
                if (i_ctx_save) begin
                    w_state_next = SAVE;
                    w_index_next = '0;
                end else if (i_ctx_restore) begin
                    w_state_next = RESTORE;
                    w_index_next = '0;
                end
            end
            SAVE, RESTORE: begin
                o_mem_req    = 1'b1;
                o_mem_we     = (r_state == SAVE);
                o_restore_we = (r_state == RESTORE) && i_mem_ack;
                if (i_mem_ack) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_index_next = r_index + PW'(1);
                    end
                end
            end
            DONE: begin
                o_ctx_done   = 1'b1;
                w_state_next = IDLE;
                w_index_next = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_index_next = '0;
            end
        endcase
    end

    assign o_busy     = (r_state != IDLE);
    assign o_mem_addr = r_index;

endmodule

// File: rtl/acc_reg_file.sv
// Accumulator-centred register file (r0 = accumulator) with whole-file
// context save/restore through a simple request/acknowledge memory port.
module acc_reg_file
    import acc_rf_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_write,
    input  logic          reg_set,
    input  logic          reg_get,
    input  logic [DW-1:0] write_data,
    input  logic [PW-1:0] op_addr,
    output logic [DW-1:0] acc_data,
    output logic [DW-1:0] op_data,
    input  logic          ctx_save,
    input  logic          ctx_restore,
    output logic          busy,
    output logic          ctx_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [PW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int N = 2**PW;

    logic [DW-1:0] w_regs [N];
    logic          w_busy;
    logic          w_restore_we;
    logic          w_wr_acc;
    logic          w_set_op;
    logic          w_get_op;

    acc_rf_ctx_seq #(
        .PW (PW)
    ) u_ctx_seq (
        .clk           (clk),
        .reset         (reset),
        .i_ctx_save    (ctx_save),
        .i_ctx_restore (ctx_restore),
        .i_mem_ack     (mem_ack),
        .o_busy        (w_busy),
        .o_ctx_done    (ctx_done),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_restore_we  (w_restore_we)
    );

    // One register operation per idle cycle, write > set > get.
    assign w_wr_acc = !w_busy && reg_write;
    assign w_set_op = !w_busy && !reg_write && reg_set;
    assign w_get_op = !w_busy && !reg_write && !reg_set && reg_get;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_reg
            logic [DW-1:0] r_reg;
            logic [DW-1:0] w_reg_next;

            if (gi == 0) begin : g_acc
                always_comb begin
                    w_reg_next = r_reg;
                    if (w_restore_we && mem_addr == PW'(gi)) begin
                        w_reg_next = mem_rdata;
                    end else if (w_wr_acc) begin
                        w_reg_next = write_data;
                    end else if (w_get_op) begin
                        w_reg_next = w_regs[op_addr];
                    end
                end
            end else begin : g_op
                always_comb begin
                    w_reg_next = r_reg;
                    if (w_restore_we && mem_addr == PW'(gi)) begin
                        w_reg_next = mem_rdata;
                    end else if (w_set_op && op_addr == PW'(gi)) begin
                        w_reg_next = w_regs[0];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_reg <= '0;
                end else begin
                    r_reg <= w_reg_next;
                end
            end

            assign w_regs[gi] = r_reg;
        end
    endgenerate

    assign acc_data  = w_regs[0];
    assign op_data   = w_regs[op_addr];
    assign mem_wdata = w_regs[mem_addr];
    assign busy      = w_busy;

endmodule
